// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter fed by two raw push buttons.
// Each button is synchronised, debounced and auto-repeats while held.
// The counter supports clear/load, carry/borrow pulses, wrap or saturate
// at the limits, and a 7-segment decode per digit.
module bcd_updown_counter_n #(
  parameter int DIGITS   = 4,
  parameter int DB_CYC   = 50000,
  parameter int RPT_DLY  = 25000000,
  parameter int RPT_RATE = 5000000,
  parameter int WRAP     = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [1:0]            i_Push,
  input  logic                  i_Clr,
  input  logic                  i_Load,
  input  logic [4*DIGITS-1:0]   i_LoadVal,
  output logic [4*DIGITS-1:0]   o_BCD,
  output logic [7*DIGITS-1:0]   o_FND,
  output logic                  o_Carry,
  output logic                  o_Borrow
);

  localparam int DB_W    = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
  localparam int RPT_MAX = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);
  localparam logic [RPT_W-1:0] DLY_VAL  = RPT_W'(RPT_DLY);
  localparam logic [RPT_W-1:0] RATE_VAL = RPT_W'(RPT_RATE);

  // bit1 = up button, bit0 = down button
  logic [1:0] db_state;
  logic [1:0] step_req;
  logic       both_held;

  logic [4*DIGITS-1:0] count_reg;
  logic                carry_reg;
  logic                borrow_reg;

  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] load_sat;
  logic                all_nines;
  logic                all_zeros;

  // Holding both buttons is treated as "no command": neither issues steps.
  assign both_held = ~db_state[0] & ~db_state[1];

  genvar gi;

  // ---------------------------------------------------------------------
  // Per-button input path: sync, debounce, press detect, auto-repeat
  // ---------------------------------------------------------------------
  for (gi = 0; gi < 2; gi++) begin : g_btn
    logic              sync1_reg;
    logic              sync2_reg;
    logic              db_reg;
    logic              db_prev_reg;
    logic [DB_W-1:0]   db_cnt_reg;
    logic [RPT_W-1:0]  rpt_cnt_reg;
    logic              first_reg;
    logic              press;
    logic              fire;

    // Press event: debounced level has just fallen (active-low button).
    assign press = db_prev_reg & ~db_reg;
    // Repeat fires on the initial delay first, then on the repeat period.
    assign fire  = ~db_reg & (rpt_cnt_reg == (first_reg ? DLY_VAL : RATE_VAL));

    assign db_state[gi] = db_reg;
    assign step_req[gi] = (press | fire) & ~both_held;

    // Two-flop synchroniser followed by a stability-count debouncer.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
        sync1_reg   <= 1'b1;
        sync2_reg   <= 1'b1;
        db_reg      <= 1'b1;
        db_prev_reg <= 1'b1;
        db_cnt_reg  <= '0;
      end else begin
        sync1_reg   <= i_Push[gi];
        sync2_reg   <= sync1_reg;
        db_prev_reg <= db_reg;
        // Agreement (or a bounce back) restarts the stability window.
        if (sync2_reg == db_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          db_reg     <= sync2_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
      end
    end

    // Hold-time counter; restarts from the initial delay whenever the
    // button is released or both buttons are held together.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
        rpt_cnt_reg <= '0;
        first_reg   <= 1'b1;
      end else if (db_reg || both_held) begin
        rpt_cnt_reg <= '0;
        first_reg   <= 1'b1;
      end else if (fire) begin
        rpt_cnt_reg <= RPT_W'(1);
        first_reg   <= 1'b0;
      end else begin
        rpt_cnt_reg <= rpt_cnt_reg + RPT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Counter datapath
  // ---------------------------------------------------------------------

  // Ripple increment/decrement across all digits in a single cycle.
  always_comb begin
    logic c_run;
    logic b_run;
    inc_val = count_reg;
    dec_val = count_reg;
    c_run   = 1'b1;
    b_run   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c_run) begin
        if (count_reg[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_reg[4*k +: 4] + 4'd1;
          c_run = 1'b0;
        end
      end
      if (b_run) begin
        if (count_reg[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_reg[4*k +: 4] - 4'd1;
          b_run = 1'b0;
        end
      end
    end
    all_nines = c_run;
    all_zeros = b_run;
  end

  // Loaded digits above 9 are clamped so the count stays valid BCD.
  for (gi = 0; gi < DIGITS; gi++) begin : g_load
    assign load_sat[4*gi +: 4] = (i_LoadVal[4*gi +: 4] > 4'd9) ? 4'd9
                                                                : i_LoadVal[4*gi +: 4];
  end

  // Count register with clear > load > step priority; pulses last one cycle.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      count_reg  <= '0;
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
    end else begin
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      if (i_Clr) begin
        count_reg <= '0;
      end else if (i_Load) begin
        count_reg <= load_sat;
      end else if (step_req[1]) begin
        carry_reg <= all_nines;
        if (!all_nines || (WRAP != 0)) begin
          count_reg <= inc_val;
        end
      end else if (step_req[0]) begin
        borrow_reg <= all_zeros;
        if (!all_zeros || (WRAP != 0)) begin
          count_reg <= dec_val;
        end
      end
    end
  end

  assign o_BCD    = count_reg;
  assign o_Carry  = carry_reg;
  assign o_Borrow = borrow_reg;

  // ---------------------------------------------------------------------
  // 7-segment decode, active-low {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------
  for (gi = 0; gi < DIGITS; gi++) begin : g_fnd
    logic [6:0] seg;

    // Decode one registered digit; non-BCD codes blank the display.
    always_comb begin
      case (count_reg[4*gi +: 4])
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end

    assign o_FND[7*gi +: 7] = seg;
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: one wrapping and one saturating
// instance; expected count events are queued as stimulus is driven and
// matched against events captured from the DUT outputs.
module tb_bcd_updown_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;            // 0 drives the wrapping DUT, 1 the saturating DUT
  logic       clr;
  logic       load;
  logic [1:0] push;
  logic [7:0] load_val;

  logic [1:0][1:0]  push_d;
  logic [1:0]       clr_d;
  logic [1:0]       load_d;
  logic [1:0][7:0]  bcd;
  logic [1:0][13:0] fnd;
  logic [1:0]       carry;
  logic [1:0]       borrow;

  assign push_d[0] = sel ? 2'b11 : push;
  assign push_d[1] = sel ? push : 2'b11;
  assign clr_d     = {sel & clr, ~sel & clr};
  assign load_d    = {sel & load, ~sel & load};

  bcd_updown_counter_n #(.DIGITS(2), .DB_CYC(4), .RPT_DLY(20), .RPT_RATE(5), .WRAP(1)) dut_wrap (
    .i_Clk(clk), .i_Rst(rst), .i_Push(push_d[0]), .i_Clr(clr_d[0]), .i_Load(load_d[0]),
    .i_LoadVal(load_val), .o_BCD(bcd[0]), .o_FND(fnd[0]), .o_Carry(carry[0]), .o_Borrow(borrow[0])
  );

  bcd_updown_counter_n #(.DIGITS(2), .DB_CYC(4), .RPT_DLY(20), .RPT_RATE(5), .WRAP(0)) dut_sat (
    .i_Clk(clk), .i_Rst(rst), .i_Push(push_d[1]), .i_Clr(clr_d[1]), .i_Load(load_d[1]),
    .i_LoadVal(load_val), .o_BCD(bcd[1]), .o_FND(fnd[1]), .o_Carry(carry[1]), .o_Borrow(borrow[1])
  );

  // cycle counter: number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor: records every count change or carry/borrow pulse
  logic            mon_en = 1'b0;
  logic [1:0][7:0] prev_bcd;
  logic [7:0]      obs_bcd [2][128];
  logic            obs_c   [2][128];
  logic            obs_b   [2][128];
  int              obs_cyc [2][128];
  int              obs_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      prev_bcd[d] <= bcd[d];
      if (mon_en && ((bcd[d] !== prev_bcd[d]) || carry[d] || borrow[d]) && (obs_cnt[d] < 128)) begin
        obs_bcd[d][obs_cnt[d]] <= bcd[d];
        obs_c[d][obs_cnt[d]]   <= carry[d];
        obs_b[d][obs_cnt[d]]   <= borrow[d];
        obs_cyc[d][obs_cnt[d]] <= cyc;
        obs_cnt[d]             <= obs_cnt[d] + 1;
      end
    end
  end

  typedef struct {
    string      tag;
    logic [7:0] bcd;
    logic       c;
    logic       bw;
    int         cy;
  } exp_t;

  exp_t qw[$];
  exp_t qs[$];
  int   rd_idx [2] = '{0, 0};
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input string tag, input logic [7:0] b, input logic c,
                           input logic bw, input int cy);
    exp_t e;
    e.tag = tag;
    e.bcd = b;
    e.c   = c;
    e.bw  = bw;
    e.cy  = cy;
    if (sel) qs.push_back(e);
    else     qw.push_back(e);
    $display("queued %s: dut=%0d bcd=%h carry=%0d borrow=%0d cycle=%0d", tag, sel, b, c, bw, cy);
  endtask

  // Match every queued expectation against captured events, then make
  // sure no unexpected events were captured.
  task automatic drain();
    exp_t e;
    int   waited;
    int   idx;
    repeat (4) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      while ((d == 0 && qw.size() > 0) || (d == 1 && qs.size() > 0)) begin
        if (d == 0) e = qw.pop_front();
        else        e = qs.pop_front();
        waited = 0;
        while (obs_cnt[d] <= rd_idx[d] && waited < 300) begin
          @(negedge clk);
          #1;
          waited++;
        end
        checks++;
        assert (obs_cnt[d] > rd_idx[d]) else begin
          failures++;
          $error("FAIL %s_arrive observed=no_event expected=event", e.tag);
        end
        if (obs_cnt[d] > rd_idx[d]) begin
          idx = rd_idx[d];
          rd_idx[d]++;
          chk($sformatf("%s_bcd", e.tag),    32'(obs_bcd[d][idx]), 32'(e.bcd));
          chk($sformatf("%s_carry", e.tag),  32'(obs_c[d][idx]),   32'(e.c));
          chk($sformatf("%s_borrow", e.tag), 32'(obs_b[d][idx]),   32'(e.bw));
          chk($sformatf("%s_cycle", e.tag),  32'(obs_cyc[d][idx]), 32'(e.cy));
          $display("event %s: dut=%0d bcd=%h carry=%0d borrow=%0d cycle=%0d", e.tag, d,
                   obs_bcd[d][idx], obs_c[d][idx], obs_b[d][idx], obs_cyc[d][idx]);
        end
      end
      chk($sformatf("extra_events_dut%0d", d), 32'(obs_cnt[d]), 32'(rd_idx[d]));
      rd_idx[d] = obs_cnt[d];
    end
  endtask

  task automatic press(input int btn, input int hold, output int t0);
    @(posedge clk);
    #1;
    push[btn] = 1'b0;
    t0 = cyc;
    repeat (hold) @(posedge clk);
    #1;
    push[btn] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic changes, input logic [7:0] exp);
    @(posedge clk);
    #1;
    load     = 1'b1;
    load_val = v;
    if (changes) expect_ev($sformatf("load_%h", v), exp, 1'b0, 1'b0, cyc + 1);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    int t0;
    rst      = 1'b0;
    sel      = 1'b0;
    push     = 2'b11;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_reset_bcd", 32'(bcd[0]), 32'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_bcd",     32'(bcd[0]), 32'h00);
    chk("rst_fnd",     32'(fnd[0]), 32'({seg(0), seg(0)}));
    chk("rst_carry",   32'(carry[0]), 32'h0);
    chk("rst_borrow",  32'(borrow[0]), 32'h0);
    chk("rst_bcd_sat", 32'(bcd[1]), 32'h00);
    #1;
    mon_en = 1'b1;

    // short bounce is ignored, then a clean press steps once with fixed latency
    @(posedge clk);
    #1;
    push[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push[1] = 1'b1;
    repeat (10) @(posedge clk);
    press(1, 10, t0);
    expect_ev("up_first", 8'h01, 1'b0, 1'b0, t0 + 7);
    drain();

    // wrap at both limits
    do_load(8'h99, 1'b1, 8'h99);
    chk("fnd_99", 32'(fnd[0]), 32'({seg(9), seg(9)}));
    press(1, 10, t0);
    expect_ev("up_wrap", 8'h00, 1'b1, 1'b0, t0 + 7);
    press(0, 10, t0);
    expect_ev("down_wrap", 8'h99, 1'b0, 1'b1, t0 + 7);
    drain();

    // digit ripple and load clamping
    do_load(8'h19, 1'b1, 8'h19);
    press(1, 10, t0);
    expect_ev("up_ripple", 8'h20, 1'b0, 1'b0, t0 + 7);
    chk("fnd_20", 32'(fnd[0]), 32'({seg(2), seg(0)}));
    do_load(8'h20, 1'b0, 8'h20);
    press(0, 10, t0);
    expect_ev("down_ripple", 8'h19, 1'b0, 1'b0, t0 + 7);
    chk("fnd_19", 32'(fnd[0]), 32'({seg(1), seg(9)}));
    do_load(8'hAF, 1'b1, 8'h99);
    drain();

    // auto-repeat while held for 40 cycles
    do_load(8'h00, 1'b1, 8'h00);
    press(1, 40, t0);
    expect_ev("hold_p",   8'h01, 1'b0, 1'b0, t0 + 7);
    expect_ev("hold_r20", 8'h02, 1'b0, 1'b0, t0 + 27);
    expect_ev("hold_r25", 8'h03, 1'b0, 1'b0, t0 + 32);
    expect_ev("hold_r30", 8'h04, 1'b0, 1'b0, t0 + 37);
    expect_ev("hold_r35", 8'h05, 1'b0, 1'b0, t0 + 42);
    drain();
    chk("hold_final", 32'(bcd[0]), 32'h05);

    // both held: silent; after down releases, up restarts its initial delay
    @(posedge clk);
    #1;
    push[1] = 1'b0;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    push[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    push[0] = 1'b1;
    repeat (28) @(posedge clk);
    #1;
    push[1] = 1'b1;
    repeat (12) @(posedge clk);
    expect_ev("both_p",   8'h06, 1'b0, 1'b0, t0 + 7);
    expect_ev("both_r20", 8'h07, 1'b0, 1'b0, t0 + 57);
    expect_ev("both_r25", 8'h08, 1'b0, 1'b0, t0 + 62);
    drain();

    // clear in the step cycle wins and suppresses carry
    do_load(8'h99, 1'b1, 8'h99);
    @(posedge clk);
    #1;
    push[1] = 1'b0;
    t0 = cyc;
    repeat (6) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push[1] = 1'b1;
    repeat (12) @(posedge clk);
    expect_ev("clr_step", 8'h00, 1'b0, 1'b0, t0 + 7);
    drain();

    // saturating instance holds at both limits but still pulses
    sel = 1'b1;
    repeat (4) @(posedge clk);
    do_load(8'h99, 1'b1, 8'h99);
    press(1, 10, t0);
    expect_ev("sat_up", 8'h99, 1'b1, 1'b0, t0 + 7);
    do_load(8'h00, 1'b1, 8'h00);
    press(0, 10, t0);
    expect_ev("sat_down", 8'h00, 1'b0, 1'b1, t0 + 7);
    drain();
    chk("sat_final", 32'(bcd[1]), 32'h00);
    chk("wrap_untouched", 32'(bcd[0]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised N-digit BCD up/down counter driven by two raw push buttons; each digit is shown on its own 7-segment display.
- Adds the following per button: synchronisation, debounce, and hold-to-auto-repeat.
- Also adds synchronous clear/load, carry/borrow pulses, and a wrap or saturate mode.
- Sits between the board push buttons/switches and the LED/FND pins. It is the general replacement for fixed two-digit counters.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
- DB_CYC, 50000, cycles a synchronised button level must be stable before it is accepted (>=2).
- RPT_DLY, 25000000, cycles a button must be held after the accepted press before the first auto-repeat step (>=1).
- RPT_RATE, 5000000, cycles between subsequent auto-repeat steps (>=1).
- WRAP, 1, 1 = wrap at the limits; 0 = saturate at the limits.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset: asynchronous, active-low.
- i_Push  in  2  raw buttons, active-low (0 = pressed); bit1 = up, bit0 = down.
- i_Clr  in  1  synchronous clear, active-high.
- i_Load  in  1  synchronous load strobe, active-high.
- i_LoadVal  in  4*DIGITS  BCD value to load; digit k occupies bits [4k+3:4k].
- o_BCD  out  4*DIGITS  current count, same digit packing as i_LoadVal.
- o_FND  out  7*DIGITS  segments for digit k at [7k+6:7k], order {g,f,e,d,c,b,a}, active-low.
- o_Carry  out  1  one-cycle pulse on an up step at the all-9s value.
- o_Borrow  out  1  one-cycle pulse on a down step at the all-0s value.

Behaviour:
- Reset (i_Rst=0, async):
  - count = 0; o_Carry = o_Borrow = 0.
  - Sync and debounced button states = 1 (released); debounce and repeat counters = 0.
  - o_FND shows "0" on every digit.
- Input path per button:
  - Two-flop synchroniser.
  - Debounce counter: cleared whenever the synchronised level equals the debounced state or changes; otherwise it increments.
  - On reaching DB_CYC-1, the debounced state takes the synchronised level and the counter clears.
- Press event: the debounced state goes 1->0. One step is issued in that same cycle.
- Auto-repeat:
  - While the debounced state stays 0, a repeat counter runs.
  - First repeat step occurs RPT_DLY cycles after the press event; further steps occur every RPT_RATE cycles.
  - Release (debounced 1) clears the repeat counter immediately; no further steps.
- Both debounced states 0: no steps are issued, and both repeat counters hold at 0. When one button is released, the other restarts from its own RPT_DLY.
- Command priority, evaluated each cycle: reset > i_Clr > i_Load > step.
  - i_Clr: count = 0.
  - i_Load: count = i_LoadVal. Any loaded digit >9 is stored as 9.
  - A step coinciding with clear/load is discarded. Carry/borrow are not asserted.
- Up step:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries to the next digit, rippling combinationally in one cycle.
  - All-9s:
    - WRAP=1: count becomes all-0s and o_Carry=1 for one cycle.
    - WRAP=0: count holds and o_Carry=1 for one cycle.
- Down step: mirror of the up step.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All-0s:
    - WRAP=1: count becomes all-9s and o_Borrow=1.
    - WRAP=0: count holds and o_Borrow=1.
- Latency:
  - The count register updates at the clock edge ending the step cycle. o_BCD and o_Carry/o_Borrow are visible in the next cycle.
  - Raw press to o_BCD change = 2 sync + DB_CYC + 1 cycles.
- o_FND:
  - Combinational decode of each digit of the registered count, active-low {g..a}:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other code decodes to 1111111 (blank); this is unreachable in normal operation.
- Bounce: a glitch shorter than DB_CYC cycles on the synchronised level causes no step.
- Reset mid-hold: all counters clear. After reset release, a still-held button must first debounce to a press event, then wait RPT_DLY before repeating.

Test Plan:
- Bench parameters: DIGITS=2, DB_CYC=4, RPT_DLY=20, RPT_RATE=5, WRAP=1.
- Reset then release: o_BCD=8'h00, o_FND={7'b1000000,7'b1000000}, o_Carry=o_Borrow=0.
- Up press, held 10 cycles then released: o_BCD goes 8'h00->8'h01 exactly 2+4+1 cycles after the edge. A 3-cycle bounce pulse before the press adds no step.
- Load 8'h99, then one up press: o_BCD=8'h00 and o_Carry high for one cycle. Then one down press: o_BCD=8'h99 and o_Borrow high for one cycle.
- Load 8'h19, then up: 8'h20. Load 8'h20, then down: 8'h19. Load 8'hAF: o_BCD=8'h99.
- Hold up for 40 cycles from 8'h00: steps at press, press+20, press+25, press+30, press+35, giving final 8'h05. Press down while up is held: no steps until one is released.
- WRAP=0 rerun: at 8'h99 up gives 8'h99 with o_Carry pulse; at 8'h00 down gives 8'h00 with o_Borrow pulse.
- i_Clr asserted in the same cycle as a step: o_BCD=8'h00, no carry/borrow.
